// File: rtl/spi_sensor_responder.sv
// SPI mode-0 slave transmitter for one sensor channel: holds the latest sample and
// shifts it out MSB-first on miso when the master's slave-select code matches SLAVE_ID.
module spi_sensor_responder #(
   parameter int DATA_W   = 8,
   parameter int SS_W     = 2,
   parameter int SLAVE_ID = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic [SS_W-1:0]   ss,
   input  logic [DATA_W-1:0] sample,
   input  logic              sample_valid,
   output logic              miso,
   output logic              busy,
   output logic              done,
   output logic              abort,
   output logic              stale
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_DESEL} state_t;

   state_t            state, state_next;
   logic              sclk_meta, sclk_sync, sclk_prev;
   logic [SS_W-1:0]   ss_meta, ss_sync;
   logic [1:0]        sync_ok;
   logic              sel, sel_prev, start, rise, fall;
   logic [DATA_W-1:0] hold_reg, shift_reg, shift_next;
   logic              hold_new, hold_new_next, saved_new, saved_next;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
   logic              miso_next, busy_next, done_next, abort_next, stale_next;

   assign sel  = (ss_sync == SS_W'(SLAVE_ID));
   assign rise = sclk_sync & ~sclk_prev;
   assign fall = ~sclk_sync & sclk_prev;
   // sel_prev stays 1 until the synchronizer holds real samples, so a select held
   // through reset never looks like a fresh rising edge.
   assign start = sync_ok[1] & sel & ~sel_prev;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_next    = state;
      shift_next    = shift_reg;
      miso_next     = 1'b0;
      bit_cnt_next  = bit_cnt;
      busy_next     = busy;
      done_next     = 1'b0;
      abort_next    = 1'b0;
      stale_next    = stale;
      hold_new_next = hold_new;
      saved_next    = saved_new;

      case (state)
         IDLE: begin
            if (start) begin
               state_next    = SHIFT;
               shift_next    = hold_reg;
               miso_next     = hold_reg[DATA_W-1];
               bit_cnt_next  = '0;
               stale_next    = ~hold_new;
               busy_next     = 1'b1;
               hold_new_next = 1'b0;
               saved_next    = hold_new;
            end
         end
         SHIFT: begin
            miso_next = miso;
            if (!sel) begin
               // Aborted transfer does not consume the sample.
               state_next    = IDLE;
               miso_next     = 1'b0;
               busy_next     = 1'b0;
               abort_next    = 1'b1;
               hold_new_next = hold_new | saved_new;
            end else if (rise) begin
               if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                  bit_cnt_next = CNT_W'(DATA_W);
                  state_next   = DONE;
                  miso_next    = 1'b0;
                  busy_next    = 1'b0;
                  done_next    = 1'b1;
               end else begin
                  bit_cnt_next = bit_cnt + CNT_W'(1);
               end
            end else if (fall && bit_cnt < CNT_W'(DATA_W)) begin
               shift_next = shift_reg << 1;
               miso_next  = shift_reg[DATA_W-2];
            end
         end
         DONE:       state_next = sel ? WAIT_DESEL : IDLE;
         WAIT_DESEL: if (!sel) state_next = IDLE;
         default:    state_next = IDLE;
      endcase

      if (sample_valid) hold_new_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (rst) begin
         state     <= IDLE;
         sclk_meta <= 1'b0;
         sclk_sync <= 1'b0;
         sclk_prev <= 1'b0;
         ss_meta   <= '0;
         ss_sync   <= '0;
         sync_ok   <= 2'b00;
         sel_prev  <= 1'b1;
         hold_reg  <= '0;
         hold_new  <= 1'b0;
         saved_new <= 1'b0;
         shift_reg <= '0;
         bit_cnt   <= '0;
         miso      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         abort     <= 1'b0;
         stale     <= 1'b0;
      end else begin
         state     <= state_next;
         sclk_meta <= sclk;
         sclk_sync <= sclk_meta;
         sclk_prev <= sclk_sync;
         ss_meta   <= ss;
         ss_sync   <= ss_meta;
         sync_ok   <= {sync_ok[0], 1'b1};
         sel_prev  <= sync_ok[1] ? sel : 1'b1;
         if (sample_valid) hold_reg <= sample;
         hold_new  <= hold_new_next;
         saved_new <= saved_next;
         shift_reg <= shift_next;
         bit_cnt   <= bit_cnt_next;
         miso      <= miso_next;
         busy      <= busy_next;
         done      <= done_next;
         abort     <= abort_next;
         stale     <= stale_next;
      end
   end

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Directed bench for spi_sensor_responder: acts as a mode-0 SPI master at clk/10
// and compares received bits and status pulses against hand-computed values.
module tb_spi_sensor_responder;

   logic       clk = 1'b0;
   logic       rst, sclk, sample_valid;
   logic [1:0] ss;
   logic [7:0] sample;
   logic       miso, busy, done, abort, stale;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0, abort_cnt = 0, busy_cnt = 0, miso_idle_hi = 0;

   spi_sensor_responder #(.DATA_W(8), .SS_W(2), .SLAVE_ID(1)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .sample(sample),
      .sample_valid(sample_valid), .miso(miso), .busy(busy), .done(done),
      .abort(abort), .stale(stale)
   );

   always #5 clk = ~clk;

   // Pulse and activity counters, sampled away from the active edge.
   always @(negedge clk) begin
      if (done)          done_cnt++;
      if (abort)         abort_cnt++;
      if (busy)          busy_cnt++;
      if (!busy && miso) miso_idle_hi++;
   end

   task automatic strobe(input logic [7:0] v);
      @(negedge clk); sample = v; sample_valid = 1'b1;
      @(negedge clk); sample_valid = 1'b0;
   endtask

   // Master transfer: select, clock nbits (sampling miso at each rise), deselect.
   task automatic xfer(input logic [1:0] code, input int nbits, input int strobe_bit,
                       input logic [7:0] new_val, output logic [7:0] got,
                       output logic b2, output logic b3, output int done_lat);
      @(negedge clk); ss = code;
      @(negedge clk);
      @(negedge clk); b2 = busy;
      @(negedge clk); b3 = busy;
      repeat (3) @(negedge clk);
      got = 8'h00;
      done_lat = -1;
      for (int i = 0; i < nbits; i++) begin
         got  = {got[6:0], miso};
         sclk = 1'b1;
         for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 5) sclk = 1'b0;
            if (i == nbits - 1 && done && done_lat < 0) done_lat = k;
            if (i == strobe_bit) begin
               if (k == 1) begin sample = new_val; sample_valid = 1'b1; end
               else sample_valid = 1'b0;
            end
         end
      end
      @(negedge clk); ss = 2'd0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; ss = 2'd0; sclk = 1'b0; sample = 8'h00; sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({miso, busy, done, abort, stale} !== 5'b0) begin
         errors++; $display("FAIL reset_outputs: got %b expected 00000", {miso, busy, done, abort, stale});
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic;
      logic [7:0] got; logic b2, b3; int lat, d0;
      strobe(8'hA5);
      d0 = done_cnt;
      xfer(2'd1, 8, -1, 8'h00, got, b2, b3, lat);
      checks++; if (got !== 8'hA5) begin errors++; $display("FAIL basic_bits: got %h expected a5", got); end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done: got %0d expected 1", done_cnt - d0); end
      checks++; if (stale !== 1'b0) begin errors++; $display("FAIL basic_stale: got %b expected 0", stale); end
      checks++; if ({b2, b3} !== 2'b01) begin errors++; $display("FAIL sel_latency: got %b expected 01", {b2, b3}); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL done_latency: got %0d expected 3", lat); end
   endtask

   task automatic test_repeat_stale;
      logic [7:0] got; logic b2, b3; int lat, d0;
      d0 = done_cnt;
      xfer(2'd1, 8, -1, 8'h00, got, b2, b3, lat);
      checks++; if (got !== 8'hA5) begin errors++; $display("FAIL repeat_bits: got %h expected a5", got); end
      checks++; if (stale !== 1'b1) begin errors++; $display("FAIL repeat_stale: got %b expected 1", stale); end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL repeat_done: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_other_slave;
      logic [7:0] got; logic b2, b3; int lat, d0, bz0;
      d0 = done_cnt; bz0 = busy_cnt;
      xfer(2'd2, 8, -1, 8'h00, got, b2, b3, lat);
      checks++; if (got !== 8'h00) begin errors++; $display("FAIL other_miso: got %h expected 00", got); end
      checks++; if (busy_cnt - bz0 !== 0) begin errors++; $display("FAIL other_busy: got %0d busy cycles expected 0", busy_cnt - bz0); end
      checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL other_done: got %0d expected 0", done_cnt - d0); end
   endtask

   task automatic test_abort;
      logic [7:0] got; logic b2, b3; int lat, d0, a0;
      strobe(8'hA5);
      d0 = done_cnt; a0 = abort_cnt;
      xfer(2'd1, 3, -1, 8'h00, got, b2, b3, lat);
      checks++; if (got !== 8'h05) begin errors++; $display("FAIL abort_bits: got %h expected 05", got); end
      checks++; if (abort_cnt - a0 !== 1) begin errors++; $display("FAIL abort_pulse: got %0d expected 1", abort_cnt - a0); end
      checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cnt - d0); end
      checks++; if ({miso, busy} !== 2'b00) begin errors++; $display("FAIL abort_idle: got %b expected 00", {miso, busy}); end
      xfer(2'd1, 8, -1, 8'h00, got, b2, b3, lat);
      checks++; if (got !== 8'hA5) begin errors++; $display("FAIL after_abort_bits: got %h expected a5", got); end
      checks++; if (stale !== 1'b0) begin errors++; $display("FAIL after_abort_stale: got %b expected 0", stale); end
   endtask

   task automatic test_mid_strobe;
      logic [7:0] got; logic b2, b3; int lat;
      xfer(2'd1, 8, 3, 8'h3C, got, b2, b3, lat);
      checks++; if (got !== 8'hA5) begin errors++; $display("FAIL mid_strobe_bits: got %h expected a5", got); end
      xfer(2'd1, 8, -1, 8'h00, got, b2, b3, lat);
      checks++; if (got !== 8'h3C) begin errors++; $display("FAIL new_sample_bits: got %h expected 3c", got); end
      checks++; if (stale !== 1'b0) begin errors++; $display("FAIL new_sample_stale: got %b expected 0", stale); end
   endtask

   task automatic test_reset_in_shift;
      logic [7:0] got; logic b2, b3; int lat, d0, bz0;
      strobe(8'h5A);
      @(negedge clk); ss = 2'd1;
      repeat (6) @(negedge clk);
      repeat (2) begin
         sclk = 1'b1; repeat (5) @(negedge clk);
         sclk = 1'b0; repeat (5) @(negedge clk);
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b expected 1", busy); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({miso, busy, done, abort, stale} !== 5'b0) begin
         errors++; $display("FAIL shift_reset_outputs: got %b expected 00000", {miso, busy, done, abort, stale});
      end
      rst = 1'b0;
      bz0 = busy_cnt;
      repeat (20) @(negedge clk);
      checks++; if (busy_cnt - bz0 !== 0) begin errors++; $display("FAIL held_sel_no_xfer: got %0d busy cycles expected 0", busy_cnt - bz0); end
      ss = 2'd0;
      repeat (6) @(negedge clk);
      d0 = done_cnt;
      xfer(2'd1, 8, -1, 8'h00, got, b2, b3, lat);
      checks++; if (got !== 8'h00) begin errors++; $display("FAIL cleared_hold_bits: got %h expected 00", got); end
      checks++; if (stale !== 1'b1) begin errors++; $display("FAIL cleared_hold_stale: got %b expected 1", stale); end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL cleared_hold_done: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_idle_miso;
      checks++;
      if (miso_idle_hi !== 0) begin errors++; $display("FAIL idle_miso: got %0d cycles high expected 0", miso_idle_hi); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_repeat_stale();
      test_other_slave();
      test_abort();
      test_mid_strobe();
      test_reset_in_shift();
      test_idle_miso();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
